// File: rtl/jtag_scan_master_pkg.sv
// Shared encodings for the JTAG scan master: FSM states, TMS preambles, TAP state codes.
// Build option JTAG_TLR_ON_RESET_EN (consumed by jtag_scan_master) adds a TAP reset walk after Reset_n.
package jtag_scan_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TLR, ST_PRE, ST_SHIFT, ST_POST, ST_RESP
  } state_e;

  // TMS preambles from Run-Test/Idle into Shift, LSB sent first
  localparam logic [2:0] DR_PRE     = 3'b001;
  localparam int         DR_PRE_CNT = 3;
  localparam logic [3:0] IR_PRE     = 4'b0011;
  localparam int         IR_PRE_CNT = 4;

  typedef enum logic [3:0] {
    TAP_TLR,    TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_e;

endpackage

// File: rtl/jtag_tck_phase.sv
// TCK generator: two Clocks per TCK (low slot, then high slot) while enabled; TCK parks low otherwise.
// fall_strobe_o marks the Clock edge that drives TCK low, rise_strobe_o the edge that drives it high.
module jtag_tck_phase (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tck_o,
  output logic fall_strobe_o,
  output logic rise_strobe_o
);

  logic ph_q;
  logic tck_q;

  assign fall_strobe_o = en_i & ~ph_q;
  assign rise_strobe_o = en_i &  ph_q;
  assign tck_o         = tck_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      ph_q  <= 1'b0;
      tck_q <= 1'b0;
    end else begin
      ph_q  <= ~ph_q;
      tck_q <= ph_q;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: IR/DR scan commands -> TCK/TMS/TDI, TDO captured LSB first into RspData.
// Define JTAG_TLR_ON_RESET_EN to walk the TAP through Test-Logic-Reset to Run-Test/Idle after reset.
module jtag_scan_master
  import jtag_scan_master_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               CmdValid,
  output logic               CmdReady,
  input  logic               CmdIsIR,
  input  logic [LEN_W-1:0]   CmdLen,
  input  logic [MAX_LEN-1:0] CmdData,
  output logic               RspValid,
  input  logic               RspReady,
  output logic [MAX_LEN-1:0] RspData,
  output logic               Busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int IDX_W = $clog2(MAX_LEN);

`ifdef JTAG_TLR_ON_RESET_EN
  localparam state_e RST_STATE = ST_TLR;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e             state_q;
  logic [LEN_W-1:0]   cnt_q, last_q, last_d, pre_last;
  logic [MAX_LEN-1:0] sh_q, cap_q;
  logic [3:0]         pre_bits;
  logic               is_ir_q, tms_q, tdi_q, busy_q, cmd_ready_q, rsp_valid_q;
  logic               tck_en, fall, rise;

  // last_d is the index of the final shift bit: 0 -> 1 bit, oversize -> clamp
  always_comb begin
    if (CmdLen == '0)                    last_d = '0;
    else if (CmdLen > LEN_W'(MAX_LEN))   last_d = LEN_W'(MAX_LEN - 1);
    else                                 last_d = CmdLen - LEN_W'(1);
  end

  assign pre_bits = is_ir_q ? IR_PRE : {1'b0, DR_PRE};
  assign pre_last = is_ir_q ? LEN_W'(IR_PRE_CNT - 1) : LEN_W'(DR_PRE_CNT - 1);
  assign tck_en   = state_q inside {ST_TLR, ST_PRE, ST_SHIFT, ST_POST};

  jtag_tck_phase u_tck (
    .clk_i         (Clock),
    .rst_ni        (Reset_n),
    .en_i          (tck_en),
    .tck_o         (TCK),
    .fall_strobe_o (fall),
    .rise_strobe_o (rise)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      last_q      <= '0;
      sh_q        <= '0;
      cap_q       <= '0;
      is_ir_q     <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CmdValid && cmd_ready_q) begin
            state_q     <= ST_PRE;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            is_ir_q     <= CmdIsIR;
            last_q      <= last_d;
            sh_q        <= CmdData;
            cap_q       <= '0;
            cnt_q       <= '0;
          end else begin
            cmd_ready_q <= 1'b1;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
          end
        end
        // five TMS=1 TCKs reach Test-Logic-Reset, the sixth (TMS=0) lands in Run-Test/Idle
        ST_TLR: begin
          if (fall) tms_q <= (cnt_q != LEN_W'(5));
          else if (cnt_q == LEN_W'(5)) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
          end else cnt_q <= cnt_q + LEN_W'(1);
        end
        ST_PRE: begin
          if (fall) tms_q <= pre_bits[cnt_q[1:0]];
          else if (cnt_q == pre_last) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + LEN_W'(1);
        end
        ST_SHIFT: begin
          if (fall) begin
            tms_q <= (cnt_q == last_q);
            tdi_q <= sh_q[0];
          end else begin
            cap_q[cnt_q[IDX_W-1:0]] <= TDO;
            sh_q                    <= sh_q >> 1;
            if (cnt_q == last_q) begin
              state_q <= ST_POST;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + LEN_W'(1);
          end
        end
        ST_POST: begin
          if (fall) begin
            tms_q <= (cnt_q == '0);
            tdi_q <= 1'b0;
          end else if (cnt_q == LEN_W'(1)) begin
            state_q <= ST_RESP;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + LEN_W'(1);
        end
        ST_RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (RspReady) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CmdReady = cmd_ready_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = cap_q;
  assign Busy     = busy_q;
  assign TMS      = tms_q;
  assign TDI      = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: TAP model (4-bit IR capturing 0001, 1-bit bypass DR) plus directed vectors.
module tb_jtag_scan_master;
  import jtag_scan_master_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic               Clock = 1'b0;
  logic               Reset_n = 1'b1;
  logic               CmdValid = 1'b0, CmdIsIR = 1'b0, RspReady = 1'b1;
  logic [LEN_W-1:0]   CmdLen = '0;
  logic [MAX_LEN-1:0] CmdData = '0;
  logic               CmdReady, RspValid, Busy, TCK, TMS, TDI, TDO;
  logic [MAX_LEN-1:0] RspData;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdIsIR(CmdIsIR), .CmdLen(CmdLen), .CmdData(CmdData), .RspValid(RspValid),
    .RspReady(RspReady), .RspData(RspData), .Busy(Busy), .TCK(TCK), .TMS(TMS),
    .TDI(TDI), .TDO(TDO)
  );

  // ---------------- TAP model (reset by Reset_n, standing in for TRST) ----------------
  tap_state_e tap_q;
  logic [3:0] ir_sh;
  logic       dr_sh;

  function automatic tap_state_e tap_next(tap_state_e s, logic m);
    case (s)
      TAP_TLR:    return m ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    return m ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: return m ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: return m ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  return m ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: return m ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: return m ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: return m ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: return m ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: return m ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: return m ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  return m ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: return m ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: return m ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: return m ? TAP_UPD_IR : TAP_SH_IR;
      default:    return m ? TAP_SEL_DR : TAP_RTI;
    endcase
  endfunction

  assign TDO = (tap_q == TAP_SH_IR) ? ir_sh[0] : dr_sh;

  always @(posedge TCK or negedge Reset_n) begin
    if (!Reset_n) begin
      tap_q <= TAP_RTI;
      ir_sh <= 4'b0;
      dr_sh <= 1'b0;
    end else begin
      case (tap_q)
        TAP_CAP_DR: dr_sh <= 1'b0;
        TAP_SH_DR:  dr_sh <= TDI;
        TAP_CAP_IR: ir_sh <= 4'b0001;
        TAP_SH_IR:  ir_sh <= {TDI, ir_sh[3:1]};
        default: ;
      endcase
      tap_q <= tap_next(tap_q, TMS);
    end
  end

  // TCK monitor: edge count, TMS history (newest in bit 0), TCKs spent in a Shift state
  int          tck_cnt = 0;
  int          sh_cnt  = 0;
  logic [63:0] tms_log = '0;
  always @(posedge TCK) begin
    tck_cnt <= tck_cnt + 1;
    tms_log <= {tms_log[62:0], TMS};
    if (tap_q == TAP_SH_DR || tap_q == TAP_SH_IR) sh_cnt <= sh_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic ir, input logic [LEN_W-1:0] len, input logic [MAX_LEN-1:0] data);
    int n = 0;
    @(negedge Clock);
    CmdIsIR = ir; CmdLen = len; CmdData = data; CmdValid = 1'b1;
    while (!CmdReady && n < 100) begin
      @(negedge Clock);
      n++;
    end
    chk("accept_wait_ok", 64'(n < 100), 64'd1);
    chk("tap_rti_at_start", 64'(tap_q), 64'(TAP_RTI));
    @(negedge Clock);
    CmdValid = 1'b0;
    chk("busy_after_accept", 64'(Busy), 64'd1);
  endtask

  // called at the negedge after the accept edge; returns Clocks from accept to RspValid
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!RspValid && lat < 300) begin
      @(negedge Clock);
      if (!RspValid) lat++;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!CmdReady && n < 50);
  endtask

  typedef struct {
    logic               ir;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] data;
    logic [MAX_LEN-1:0] rsp;
    int                 tcks;
    int                 nbits;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, n, t0, s0;

    vecs[0] = '{1'b0, 6'd8,  32'h0000_00A5, 32'h0000_004A, 13, 8};
    vecs[1] = '{1'b1, 6'd4,  32'h0000_000F, 32'h0000_0001, 10, 4};
    vecs[2] = '{1'b0, 6'd0,  32'h0000_0001, 32'h0000_0000, 6,  1};
    vecs[3] = '{1'b0, 6'd40, 32'hDEAD_BEEF, 32'hBD5B_7DDE, 37, 32};
    vecs[4] = '{1'b0, 6'd32, 32'h8000_0001, 32'h0000_0002, 37, 32};
    vecs[5] = '{1'b1, 6'd8,  32'h0000_003C, 32'h0000_00C1, 14, 8};
    vecs[6] = '{1'b0, 6'd33, 32'h1234_5678, 32'h2468_ACF0, 37, 32};

    // ---- reset values ----
    #1 Reset_n = 1'b0;
    @(negedge Clock); @(negedge Clock);
    chk("rst_cmd_ready", 64'(CmdReady), 64'd0);
    chk("rst_rsp_valid", 64'(RspValid), 64'd0);
    chk("rst_rsp_data",  64'(RspData),  64'd0);
    chk("rst_busy",      64'(Busy),     64'd0);
    chk("rst_tck",       64'(TCK),      64'd0);
    chk("rst_tms",       64'(TMS),      64'd1);
    chk("rst_tdi",       64'(TDI),      64'd0);
    t0 = tck_cnt;
    Reset_n = 1'b1;
    wait_ready(n);
`ifdef JTAG_TLR_ON_RESET_EN
    chk("tlr_ready_delay", 64'(n), 64'd12);
    chk("tlr_tck_count",   64'(tck_cnt - t0), 64'd6);
    chk("tlr_tms_seq",     tms_log[5:0], 64'b111110);
`else
    chk("ready_delay", 64'(n), 64'd1);
`endif
    chk("idle_tms", 64'(TMS), 64'd0);

    // ---- table of single scans, response consumed immediately ----
    for (int i = 0; i < 7; i++) begin
      t0 = tck_cnt; s0 = sh_cnt;
      send(vecs[i].ir, vecs[i].len, vecs[i].data);
      wait_rsp(lat);
      chk($sformatf("v%0d_rsp_data", i), 64'(RspData), 64'(vecs[i].rsp));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(2 * vecs[i].tcks + 1));
      chk($sformatf("v%0d_tck_count", i), 64'(tck_cnt - t0), 64'(vecs[i].tcks));
      chk($sformatf("v%0d_shift_tcks", i), 64'(sh_cnt - s0), 64'(vecs[i].nbits));
      chk($sformatf("v%0d_tms_tail", i), 64'(tms_log[2:0]), 64'b110);
      chk($sformatf("v%0d_tap_rti_end", i), 64'(tap_q), 64'(TAP_RTI));
      chk($sformatf("v%0d_busy_done", i), 64'(Busy), 64'd0);
      chk($sformatf("v%0d_tck_low", i), 64'(TCK), 64'd0);
      if (vecs[i].ir && vecs[i].len == 6'd4)
        chk("ir_tms_sequence", 64'(tms_log[9:0]), 64'b1100000110);
    end

    // ---- back-to-back DR scans, CmdValid held, RspReady tied 1 ----
    t0 = tck_cnt;
    @(negedge Clock);
    CmdIsIR = 1'b0; CmdLen = 6'd3; CmdData = 32'h5; CmdValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge Clock);
      while (!RspValid && n < 100) begin
        @(negedge Clock);
        n++;
      end
      if (k == 2) CmdValid = 1'b0;
      chk($sformatf("b2b%0d_rsp_data", k), 64'(RspData), 64'h2);
      chk($sformatf("b2b%0d_tap_rti", k), 64'(tap_q), 64'(TAP_RTI));
    end
    @(negedge Clock); @(negedge Clock);
    chk("b2b_tck_total", 64'(tck_cnt - t0), 64'd24);

    // ---- response stall with a pending command ----
    RspReady = 1'b0;
    send(1'b0, 6'd8, 32'h5A);
    wait_rsp(lat);
    chk("stall_latency", 64'(lat), 64'd27);
    CmdIsIR = 1'b0; CmdLen = 6'd4; CmdData = 32'h3; CmdValid = 1'b1;
    t0 = tck_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      chk("stall_rsp_valid", 64'(RspValid), 64'd1);
      chk("stall_rsp_data",  64'(RspData),  64'hB4);
      chk("stall_cmd_ready", 64'(CmdReady), 64'd0);
      chk("stall_busy",      64'(Busy),     64'd0);
    end
    chk("stall_no_tck", 64'(tck_cnt - t0), 64'd0);
    RspReady = 1'b1;
    @(negedge Clock);
    chk("consume_rsp_valid", 64'(RspValid), 64'd0);
    chk("consume_cmd_ready", 64'(CmdReady), 64'd1);
    chk("consume_busy",      64'(Busy),     64'd0);
    @(negedge Clock);
    CmdValid = 1'b0;
    chk("next_accept_busy", 64'(Busy), 64'd1);
    wait_rsp(lat);
    chk("next_latency",  64'(lat),     64'd19);
    chk("next_rsp_data", 64'(RspData), 64'h6);

    // ---- reset in the middle of the shift ----
    t0 = tck_cnt;
    send(1'b0, 6'd8, 32'hFF);
    n = 0;
    while ((tck_cnt - t0) < 6 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    chk("abort_reached_shift", 64'(tck_cnt - t0), 64'd6);
    Reset_n = 1'b0;
    @(negedge Clock);
    chk("abort_tck",       64'(TCK),      64'd0);
    chk("abort_tms",       64'(TMS),      64'd1);
    chk("abort_busy",      64'(Busy),     64'd0);
    chk("abort_rsp_valid", 64'(RspValid), 64'd0);
    chk("abort_rsp_data",  64'(RspData),  64'd0);
    chk("abort_cmd_ready", 64'(CmdReady), 64'd0);
    t0 = tck_cnt;
    Reset_n = 1'b1;
    wait_ready(n);
`ifdef JTAG_TLR_ON_RESET_EN
    chk("abort_tlr_delay", 64'(n), 64'd12);
    chk("abort_tlr_tcks",  64'(tck_cnt - t0), 64'd6);
    chk("abort_tlr_tms",   tms_log[5:0], 64'b111110);
`else
    chk("abort_ready_delay", 64'(n), 64'd1);
`endif
    send(1'b0, 6'd8, 32'hA5);
    wait_rsp(lat);
    chk("recover_rsp_data", 64'(RspData), 64'h4A);
    chk("recover_latency",  64'(lat),     64'd27);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
